// File: rtl/echo_indication_output_pkg.sv
// Shared message layout for the echo indication path: width, tags and field offsets.
// Used by the output-side serializer and the matching input-side decoder.
package echo_indication_output_pkg;

    localparam int unsigned MsgWidth  = 96;
    localparam int unsigned TagWidth  = 32;

    localparam logic [TagWidth-1:0] TagHeard  = 32'd1;
    localparam logic [TagWidth-1:0] TagHeard2 = 32'd2;

    localparam int unsigned TagLsb       = 0;
    localparam int unsigned HeardMethLsb = 32;
    localparam int unsigned HeardVLsb    = 64;
    localparam int unsigned Heard2ALsb   = 32;
    localparam int unsigned Heard2BLsb   = 48;

    typedef logic [MsgWidth-1:0] msg_t;

    function automatic msg_t pack_heard(logic [31:0] meth, logic [31:0] v);
        msg_t m;
        m = '0;
        m[TagLsb +: TagWidth]  = TagHeard;
        m[HeardMethLsb +: 32]  = meth;
        m[HeardVLsb +: 32]     = v;
        return m;
    endfunction

    function automatic msg_t pack_heard2(logic [15:0] a, logic [15:0] b);
        msg_t m;
        m = '0;
        m[TagLsb +: TagWidth] = TagHeard2;
        m[Heard2ALsb +: 16]   = a;
        m[Heard2BLsb +: 16]   = b;
        return m;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// DEPTH-entry message FIFO with two ordered write ports (port 0 lands first) and one read port.
// No write-to-read bypass: a written entry becomes visible on rd_data the following cycle.
module msg_fifo
    import echo_indication_output_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr0_en,
    input  msg_t                     wr0_data,
    input  logic                     wr1_en,
    input  msg_t                     wr1_data,
    input  logic                     rd_en,
    output msg_t                     rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    msg_t            mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] wr1_addr;
    logic [1:0]      n_wr;

    always_comb begin
        n_wr     = {1'b0, wr0_en} + {1'b0, wr1_en};
        // Port 1 follows port 0 when both write in the same cycle.
        wr1_addr = wptr_q + PtrW'(wr0_en);
        rd_data  = mem_q[rptr_q];
        count    = count_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr0_en) begin
                mem_q[wptr_q] <= wr0_data;
            end
            if (wr1_en) begin
                mem_q[wr1_addr] <= wr1_data;
            end
            wptr_q <= wptr_q + PtrW'(n_wr);
            if (rd_en) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(n_wr) - CntW'(rd_en);
        end
    end

endmodule

// File: rtl/echo_indication_output.sv
// Serializes heard/heard2 indications into 96-bit messages and offers them on the pipe.
// RDY outputs depend only on the registered FIFO count, never on the ENA inputs.
module echo_indication_output
    import echo_indication_output_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        indication_heard__ENA,
    input  logic [31:0] indication_heard_meth,
    input  logic [31:0] indication_heard_v,
    output logic        indication_heard__RDY,
    input  logic        indication_heard2__ENA,
    input  logic [15:0] indication_heard2_a,
    input  logic [15:0] indication_heard2_b,
    output logic        indication_heard2__RDY,
    output logic        pipe_enq__ENA,
    output logic [95:0] pipe_enq_v,
    input  logic        pipe_enq__RDY
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [CntW-1:0] count;
    msg_t            head;
    logic            heard_fire, heard2_fire;
    logic            wr0_en, wr1_en, rd_en;
    msg_t            wr0_data, wr1_data;

    always_comb begin
        // heard2 keeps one slot in reserve so both methods may fire together.
        indication_heard__RDY  = !RST && (count < CntW'(DEPTH));
        indication_heard2__RDY = !RST && (count < CntW'(DEPTH - 1));

        heard_fire  = indication_heard__ENA && indication_heard__RDY;
        heard2_fire = indication_heard2__ENA && indication_heard2__RDY;

        wr0_en   = heard_fire || heard2_fire;
        wr1_en   = heard_fire && heard2_fire;
        wr0_data = heard_fire ? pack_heard(indication_heard_meth, indication_heard_v)
                              : pack_heard2(indication_heard2_a, indication_heard2_b);
        wr1_data = pack_heard2(indication_heard2_a, indication_heard2_b);

        pipe_enq__ENA = !RST && (count != '0);
        pipe_enq_v    = RST ? '0 : head;
        rd_en         = pipe_enq__ENA && pipe_enq__RDY;
    end

    msg_fifo #(
        .DEPTH (DEPTH)
    ) u_msg_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (rd_en),
        .rd_data  (head),
        .count    (count)
    );

endmodule

// File: tb/tb_echo_indication_output.sv
// Randomized bench for echo_indication_output against a queue-based message model.
module tb_echo_indication_output;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST;
    logic        h_ena;
    logic [31:0] h_meth, h_v;
    logic        h_rdy;
    logic        h2_ena;
    logic [15:0] h2_a, h2_b;
    logic        h2_rdy;
    logic        enq_ena;
    logic [95:0] enq_v;
    logic        prdy;

    int checks = 0;
    int errors = 0;

    logic [95:0] q[$];

    echo_indication_output #(
        .DEPTH (DEPTH)
    ) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .indication_heard__ENA  (h_ena),
        .indication_heard_meth  (h_meth),
        .indication_heard_v     (h_v),
        .indication_heard__RDY  (h_rdy),
        .indication_heard2__ENA (h2_ena),
        .indication_heard2_a    (h2_a),
        .indication_heard2_b    (h2_b),
        .indication_heard2__RDY (h2_rdy),
        .pipe_enq__ENA          (enq_ena),
        .pipe_enq_v             (enq_v),
        .pipe_enq__RDY          (prdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [95:0] m_heard(logic [31:0] meth, logic [31:0] v);
        return {v, meth, 32'd1};
    endfunction

    function automatic logic [95:0] m_heard2(logic [15:0] a, logic [15:0] b);
        return {32'd0, b, a, 32'd2};
    endfunction

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic step();
        bit hr, h2r, deq;
        hr  = q.size() < DEPTH;
        h2r = q.size() < DEPTH - 1;
        deq = (q.size() != 0) && prdy;
        if (RST) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (h_ena && hr) q.push_back(m_heard(h_meth, h_v));
            if (h2_ena && h2r) q.push_back(m_heard2(h2_a, h2_b));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        h_ena = 0; h2_ena = 0;
    endtask

    task automatic test_reset();
        RST = 1; h_ena = 1; h2_ena = 1; prdy = 1;
        h_meth = $urandom(); h_v = $urandom(); h2_a = 16'h1; h2_b = 16'h2;
        repeat (3) step();
        checks++; if (enq_ena !== 1'b0) begin errors++; $display("FAIL reset_ena got %b want 0", enq_ena); end
        checks++; if (enq_v !== 96'd0) begin errors++; $display("FAIL reset_v got %h want 0", enq_v); end
        checks++; if (h_rdy !== 1'b0 || h2_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_rdy got %b%b want 00", h_rdy, h2_rdy); end
        RST = 0; idle_inputs();
        #1;
        checks++; if (enq_ena !== 1'b0) begin errors++; $display("FAIL post_reset_ena got %b want 0", enq_ena); end
        checks++; if (h_rdy !== 1'b1 || h2_rdy !== 1'b1) begin
            errors++; $display("FAIL post_reset_rdy got %b%b want 11", h_rdy, h2_rdy); end
    endtask

    task automatic test_single();
        prdy = 1; h_ena = 1; h_meth = 32'd5; h_v = 32'h1234;
        step();
        idle_inputs();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 96'h00001234_00000005_00000001) begin
            errors++; $display("FAIL single_msg got ena=%b v=%h want 1 %h", enq_ena, enq_v,
                               96'h00001234_00000005_00000001); end
        step();
        checks++; if (enq_ena !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", enq_ena); end
    endtask

    task automatic test_dual();
        prdy = 0; h_ena = 1; h_meth = 32'd7; h_v = 32'd9;
        h2_ena = 1; h2_a = 16'hBEEF; h2_b = 16'h0011;
        step();
        idle_inputs();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 96'h00000009_00000007_00000001) begin
            errors++; $display("FAIL dual_first got ena=%b v=%h", enq_ena, enq_v); end
        prdy = 1;
        step();
        checks++; if (enq_ena !== 1'b1 || enq_v !== 96'h00000000_0011BEEF_00000002) begin
            errors++; $display("FAIL dual_second got ena=%b v=%h", enq_ena, enq_v); end
        step();
        checks++; if (enq_ena !== 1'b0) begin errors++; $display("FAIL dual_empty got %b want 0", enq_ena); end
    endtask

    task automatic test_full();
        logic [95:0] exp[$];
        int got;
        prdy = 0;
        for (int i = 0; i < 3; i++) begin
            h_ena = 1; h_meth = $urandom(); h_v = $urandom();
            exp.push_back(m_heard(h_meth, h_v));
            step();
        end
        idle_inputs();
        checks++; if (h_rdy !== 1'b1 || h2_rdy !== 1'b0) begin
            errors++; $display("FAIL three_rdy got %b%b want 10", h_rdy, h2_rdy); end
        h_ena = 1; h_meth = $urandom(); h_v = $urandom();
        exp.push_back(m_heard(h_meth, h_v));
        step();
        checks++; if (h_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b want 0", h_rdy); end
        h_meth = 32'hDEAD; h_v = 32'hBEEF;
        step();
        idle_inputs();
        // Dequeue while full: RDY must not rise within this cycle.
        prdy = 1;
        #1;
        checks++; if (h_rdy !== 1'b0) begin errors++; $display("FAIL no_bypass_rdy got %b want 0", h_rdy); end
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (enq_ena && got < exp.size()) begin
                checks++; if (enq_v !== exp[got]) begin
                    errors++; $display("FAIL full_order[%0d] got %h want %h", got, enq_v, exp[got]); end
                got++;
            end else if (enq_ena) begin
                got++;
            end
            step();
            if (c == 0) begin
                checks++; if (h_rdy !== 1'b1) begin
                    errors++; $display("FAIL rdy_after_deq got %b want 1", h_rdy); end
            end
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL full_count got %0d want 4", got); end
    endtask

    task automatic test_reset_mid();
        prdy = 0;
        for (int i = 0; i < 2; i++) begin
            h_ena = 1; h_meth = $urandom(); h_v = $urandom();
            step();
        end
        RST = 1;
        step();
        checks++; if (enq_ena !== 1'b0 || enq_v !== 96'd0) begin
            errors++; $display("FAIL mid_reset_out got ena=%b v=%h want 0 0", enq_ena, enq_v); end
        RST = 0; idle_inputs(); prdy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (enq_ena !== 1'b0) begin
                errors++; $display("FAIL stale_msg cycle %0d got ena=%b v=%h", i, enq_ena, enq_v); end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [95:0] exp[$];
        int sent, got;
        sent = 0; got = 0;
        prdy = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            prdy = ~prdy;
            h_ena = (sent < 10);
            h_meth = $urandom(); h_v = $urandom();
            if (h_ena && q.size() < DEPTH) begin
                exp.push_back(m_heard(h_meth, h_v));
                sent++;
            end
            if (enq_ena && prdy) begin
                checks++; if (got >= exp.size() || enq_v !== exp[got]) begin
                    errors++; $display("FAIL wrap_msg[%0d] got %h", got, enq_v); end
                got++;
            end
            step();
        end
        idle_inputs();
        checks++; if (got !== 10) begin errors++; $display("FAIL wrap_count got %0d want 10", got); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            h_ena = $urandom_range(0, 1); h2_ena = $urandom_range(0, 1);
            prdy = ($urandom_range(0, 3) != 0);
            h_meth = $urandom(); h_v = $urandom();
            h2_a = 16'($urandom()); h2_b = 16'($urandom());
            #1;
            checks++; if (enq_ena !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_ena cycle %0d got %b want %b", c, enq_ena, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (enq_v !== q[0]) begin
                    errors++; $display("FAIL rand_v cycle %0d got %h want %h", c, enq_v, q[0]); end
            end
            checks++; if (h_rdy !== (q.size() < DEPTH) || h2_rdy !== (q.size() < DEPTH - 1)) begin
                errors++; $display("FAIL rand_rdy cycle %0d got %b%b size %0d", c, h_rdy, h2_rdy, q.size()); end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        RST = 1; h_ena = 0; h2_ena = 0; prdy = 0;
        h_meth = 0; h_v = 0; h2_a = 0; h2_b = 0;
        @(posedge CLK); #1;
        test_reset();
        test_single();
        test_dual();
        test_full();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
